// File: rtl/bcd_divider_if.sv
// rtl/bcd_divider_if.sv - request/result bundle for bcd_divider (optional BCD_DIV_BIN_OUT_EN adds quotient_bin)
interface bcd_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       err;
`ifdef BCD_DIV_BIN_OUT_EN
    logic [6:0] quotient_bin;
`endif

    // Requester side: drives the operands, observes the result
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, err
`ifdef BCD_DIV_BIN_OUT_EN
        , input quotient_bin
`endif
    );

    // Divider side: samples the operands, drives the result
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, err
`ifdef BCD_DIV_BIN_OUT_EN
        , output quotient_bin
`endif
    );
endinterface

// File: rtl/bcd_divider.sv
// rtl/bcd_divider.sv - 2-digit by 1-digit BCD divider by repeated subtraction (optional BCD_DIV_BIN_OUT_EN binary quotient)
module bcd_divider (
    input  logic          clk,
    input  logic          rst_n,
    bcd_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_dividend;
    logic [3:0] r_divisor;
    logic [6:0] r_work;
    logic [7:0] r_quot;
    logic [3:0] r_rem;
    logic       r_err;
`ifdef BCD_DIV_BIN_OUT_EN
    logic [6:0] r_qbin;
`endif

    logic       w_busy;
    logic       w_done;
    logic       w_dvd_bad;
    logic       w_dvs_bad;
    logic       w_any_bad;
    logic       w_ge;
    logic [6:0] w_tens7;
    logic [6:0] w_work_init;
    logic [7:0] w_quot_inc;

    // Operand validity: any nibble above 9 is not BCD; divisor 0 is undefined
    assign w_dvd_bad = (r_dividend[7:4] > 4'd9) || (r_dividend[3:0] > 4'd9);
    assign w_dvs_bad = (r_divisor > 4'd9) || (r_divisor == 4'd0);
    assign w_any_bad = w_dvd_bad || w_dvs_bad;

    // tens*10 + units built from shifts so no multiplier is needed
    assign w_tens7     = {3'b000, r_dividend[7:4]};
    assign w_work_init = (w_tens7 << 3) + (w_tens7 << 1) + {3'b000, r_dividend[3:0]};

    assign w_ge = (r_work >= {3'b000, r_divisor});

    // Decimal increment of the quotient; saturates at 99 although valid operands never reach past it
    always_comb begin
        w_quot_inc = r_quot;
        if (r_quot != 8'h99) begin
            if (r_quot[3:0] == 4'd9) begin
                w_quot_inc = {r_quot[7:4] + 4'd1, 4'd0};
            end else begin
                w_quot_inc = {r_quot[7:4], r_quot[3:0] + 4'd1};
            end
        end
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore status outputs
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_busy = 1'b1;
                w_next = w_any_bad ? S_DONE : S_SUB;
            end
            S_SUB: begin
                w_busy = 1'b1;
                if (!w_ge) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, validity check, subtract/count loop, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= 8'h00;
            r_divisor  <= 4'h0;
            r_work     <= 7'd0;
            r_quot     <= 8'h00;
            r_rem      <= 4'h0;
            r_err      <= 1'b0;
`ifdef BCD_DIV_BIN_OUT_EN
            r_qbin     <= 7'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                        r_quot     <= 8'h00;
                        r_err      <= 1'b0;
`ifdef BCD_DIV_BIN_OUT_EN
                        r_qbin     <= 7'd0;
`endif
                    end
                end
                S_CHECK: begin
                    if (w_any_bad) begin
                        r_quot <= {(w_dvd_bad ? 4'hF : 4'h0), (w_dvs_bad ? 4'hF : 4'h0)};
                        r_rem  <= 4'hF;
                        r_err  <= 1'b1;
`ifdef BCD_DIV_BIN_OUT_EN
                        r_qbin <= 7'h7F;
`endif
                    end else begin
                        r_work <= w_work_init;
                    end
                end
                S_SUB: begin
                    if (w_ge) begin
                        r_work <= r_work - {3'b000, r_divisor};
                        r_quot <= w_quot_inc;
`ifdef BCD_DIV_BIN_OUT_EN
                        r_qbin <= r_qbin + 7'd1;
`endif
                    end else begin
                        // Working remainder is below the divisor, so it fits one BCD digit
                        r_rem <= r_work[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.err       = r_err;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
`ifdef BCD_DIV_BIN_OUT_EN
    assign bus.quotient_bin = r_qbin;
`endif

endmodule

// File: doc/bcd_divider.md
BCD_DIVIDER -- requirements
Module: bcd_divider

Interface
REQ-001 Parameter: none; all widths fixed (2-digit BCD dividend, 1-digit BCD divisor).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; operands sampled on the edge where start=1 and state IDLE.
REQ-005 dividend  input  8  packed BCD: [7:4] tens digit, [3:0] units digit.
REQ-006 divisor  input  4  BCD digit.
REQ-007 quotient  output  8  packed BCD result; a nibble of 'hF marks an invalid operand.
REQ-008 remainder  output  4  BCD digit; 'hF on any error.
REQ-009 busy  output  1  high in CHECK and SUB states.
REQ-010 done  output  1  one-cycle pulse when results become valid.
REQ-011 err  output  1  high with done when any operand error is detected; held until next accepted start.

Function
REQ-012 The FSM SHALL have states IDLE, CHECK, SUB, DONE; DONE always returns to IDLE on the next edge.
REQ-013 IDLE: start=1 SHALL latch dividend and divisor, clear the quotient counter and err, and go to CHECK; start=0 stays in IDLE.
REQ-014 start SHALL be ignored in CHECK, SUB and DONE; latched operands do not change.
REQ-015 CHECK: a dividend with either digit >9 SHALL set quotient[7:4]='hF.
REQ-016 CHECK: a divisor >9 or =0 SHALL set quotient[3:0]='hF; both nibble errors may coexist.
REQ-017 On any CHECK error: remainder='hF, err=1, next state DONE; otherwise the working remainder = tens*10+units (7-bit binary), next state SUB.
REQ-018 SUB: if working remainder >= divisor, subtract divisor and increment quotient as BCD (units 9->0 with carry into tens); else go to DONE.
REQ-019 Quotient increment SHALL never exceed 99; units roll over only via decimal carry.
REQ-020 DONE: remainder SHALL equal the working remainder (0-8, valid BCD), done=1 for exactly this cycle.
REQ-021 Latency from the accepting edge to done high SHALL be q+3 cycles for valid operands (q = binary quotient), 2 cycles on error.
REQ-022 quotient, remainder, err SHALL hold their values after DONE until the next accepted start.
REQ-023 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, quotient=8'h00, remainder=4'h0, busy=0, done=0, err=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse is produced for the aborted request.
REQ-026 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-027 Macro BCD_DIV_BIN_OUT_EN defined: an extra output quotient_bin (7 bits, binary quotient 0-99), updated alongside quotient, 7'h7F on error, 0 on reset.
REQ-028 Macro BCD_DIV_BIN_OUT_EN undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 dividend=8'h94, divisor=9, start pulse -> done after 13 cycles, quotient=8'h10, remainder=4, err=0.
REQ-030 dividend=8'h27, divisor=7 -> done after 6 cycles, quotient=8'h03, remainder=6; dividend=8'h00, divisor=5 -> done after 3 cycles, quotient=8'h00, remainder=0.
REQ-031 dividend=8'h3D, divisor=3 -> done after 2 cycles, quotient=8'hF0, remainder='hF, err=1; dividend=8'hA5, divisor=0 -> quotient=8'hFF, err=1.
REQ-032 dividend=8'h99, divisor=1 -> done after 102 cycles, quotient=8'h99, remainder=0 (decimal carry across 09->10 ... 89->90 checked).
REQ-033 Start 8'h50/5, pulse start again with 8'h12/3 while busy -> second request ignored, result quotient=8'h10, remainder=0.
REQ-034 Start 8'h81/2, drop rst_n after 5 cycles -> all outputs 0 immediately, no done; then 8'h81/2 -> quotient=8'h40, remainder=1.
